// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential fractional multiplier
package mult_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Largest positive Q1.(w-1) code, used as the saturation value.
  function automatic logic [31:0] sat_pos(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/mult_shift_add.sv
// rtl/mult_shift_add.sv - unsigned shift-add datapath; multiplier shares the low accumulator half
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH:0]   product_hi_o
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     sum;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  // The carry out of the upper-half add is shifted straight back in.
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    if (load_i) begin
      mcand_d = mcand_i;
      acc_d   = {{WIDTH{1'b0}}, mplier_i};
    end else if (step_i) begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  assign product_hi_o = acc_q[2*WIDTH-1:WIDTH-1];

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - MUL sequencer: stalls the PC, runs shift-add, writes back saturated Q1.(W-1)
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic             mult_flag,
  output logic             stall,
  output logic             reg_we,
  output logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] abs_rd1, abs_rd2;
  logic [WIDTH:0]   product_hi;
  logic [WIDTH-1:0] mag_sat, result;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  assign abs_rd1 = abs_val(rd1);
  assign abs_rd2 = abs_val(rd2);

  mult_shift_add #(.WIDTH(WIDTH)) u_core (
    .clk          (clk),
    .n_reset      (n_reset),
    .load_i       (state_q == LOAD),
    .step_i       (state_q == RUN),
    .mcand_i      (abs_rd1),
    .mplier_i     (abs_rd2),
    .product_hi_o (product_hi)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      count_q <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sign_d  = sign_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        sign_d  = rd1[WIDTH-1] ^ rd2[WIDTH-1];
        count_d = CW'(WIDTH - 1);
        state_d = RUN;
      end
      RUN: begin
        if (count_q == '0) state_d = WRITE;
        else               count_d = count_q - CW'(1);
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A magnitude of 2^(W-1) or more can only come from -1 * -1, whose sign is positive.
  always_comb begin
    mag_sat   = (product_hi[WIDTH] | product_hi[WIDTH-1]) ? SAT_POS : product_hi[WIDTH-1:0];
    result    = sign_q ? (~mag_sat + WIDTH'(1)) : mag_sat;
    mult_flag = (state_q == LOAD) || (state_q == WRITE);
    busy      = (state_q != IDLE);
    reg_we    = (state_q == WRITE);
    done      = (state_q == WRITE);
    wdata     = (state_q == WRITE) ? result : '0;
    stall     = busy || ((state_q == IDLE) && start);
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - directed self-checking bench for mult_seq
module tb_mult_seq;

  logic       clk;
  logic       n_reset;
  logic       start;
  logic [7:0] rd1, rd2;
  logic       mult_flag, stall, reg_we, busy, done;
  logic [7:0] wdata;

  int tests, errors;
  int n_we, first_we, last_we, stall_cnt, flag_cnt, busy_cnt, bad_cnt;
  logic [7:0] wd_at_we;
  logic rst_zero;

  mult_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (start),
    .rd1       (rd1),
    .rd2       (rd2),
    .mult_flag (mult_flag),
    .stall     (stall),
    .reg_we    (reg_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the cycle in which start is first driven high; extra[k] re-pulses start at cycle k.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [31:0] extra,
                        input int ncyc, input int rst_at);
    n_we = 0; first_we = -1; last_we = -1; wd_at_we = 8'h00;
    stall_cnt = 0; flag_cnt = 0; busy_cnt = 0; bad_cnt = 0; rst_zero = 1'b0;
    @(negedge clk);
    rd1 = a;
    rd2 = b;
    for (int k = 0; k < ncyc; k++) begin
      start = (k == 0) || extra[k];
      if (k == rst_at) n_reset = 1'b0;
      #1;
      if (reg_we) begin
        n_we++;
        if (first_we < 0) begin
          first_we = k;
          wd_at_we = wdata;
        end
        last_we = k;
      end
      if (stall)     stall_cnt++;
      if (mult_flag) flag_cnt++;
      if (busy)      busy_cnt++;
      if ((done !== reg_we) || (!reg_we && wdata !== 8'h00)) bad_cnt++;
      if (k == rst_at)
        rst_zero = ({mult_flag, stall, reg_we, busy, done} == 5'b0) && (wdata == 8'h00);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  logic [7:0] va [7];
  logic [7:0] vb [7];
  logic [7:0] vr [7];

  initial begin
    tests = 0; errors = 0;
    n_reset = 1'b1; start = 1'b0; rd1 = 8'h00; rd2 = 8'h00;
    va = '{8'h40, 8'hC0, 8'hC0, 8'h80, 8'h80, 8'h00, 8'h01};
    vb = '{8'h40, 8'h40, 8'hC0, 8'h80, 8'h7F, 8'h80, 8'h01};
    vr = '{8'h20, 8'hE0, 8'h20, 8'h7F, 8'h81, 8'h00, 8'h00};

    #2 n_reset = 1'b0;
    #1;
    check("rst_ctrl", {27'b0, mult_flag, stall, reg_we, busy, done}, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    run_op(8'h40, 8'h40, 32'h0, 12, -1);
    check("t0_we_cycle", first_we, 10);
    check("t0_we_count", n_we, 1);
    check("t0_wdata", wd_at_we, 8'h20);
    check("t0_stall_cycles", stall_cnt, 11);
    check("t0_flag_cycles", flag_cnt, 2);
    check("t0_busy_cycles", busy_cnt, 10);
    check("t0_done_wdata_idle", bad_cnt, 0);

    for (int i = 1; i < 7; i++) begin
      run_op(va[i], vb[i], 32'h0, 12, -1);
      check($sformatf("v%0d_wdata", i), wd_at_we, vr[i]);
      check($sformatf("v%0d_we_cycle", i), first_we, 10);
      check($sformatf("v%0d_we_count", i), n_we, 1);
    end

    run_op(8'h40, 8'h40, 32'h0000_0408, 12, -1);
    check("repulse_we_count", n_we, 1);
    check("repulse_we_cycle", first_we, 10);
    check("repulse_stall_cycles", stall_cnt, 11);

    run_op(8'hC0, 8'h40, 32'h0000_0C08, 24, -1);
    check("b2b_we_count", n_we, 2);
    check("b2b_first_we", first_we, 10);
    check("b2b_second_we", last_we, 21);
    check("b2b_wdata", wd_at_we, 8'hE0);
    check("b2b_stall_cycles", stall_cnt, 22);

    run_op(8'h40, 8'h40, 32'h0, 14, 5);
    check("midrst_outputs_zero", rst_zero, 1);
    check("midrst_no_we", n_we, 0);
    check("midrst_busy_cycles", busy_cnt, 4);
    n_reset = 1'b1;

    run_op(8'h80, 8'h7F, 32'h0, 12, -1);
    check("postrst_we_cycle", first_we, 10);
    check("postrst_wdata", wd_at_we, 8'h81);
    check("postrst_stall_cycles", stall_cnt, 11);
    check("postrst_done_wdata_idle", bad_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
